// File: rtl/game_pkg.sv
// Shared definitions for the bounce-ball game: state encodings and the
// default gameplay constants. Imported by game_ctrl and also by the graphics
// and text-overlay blocks so that everybody decodes the debug state the same
// way.
package game_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PLAY    = 3'd1,
      S_DYING   = 3'd2,
      S_NEWBALL = 3'd3,
      S_OVER    = 3'd4,
      S_WIN     = 3'd5
   } game_state_t;

   localparam int LIFE_INIT_DEF      = 3;
   localparam int WIN_SCORE_DEF      = 1;
   localparam int RESPAWN_FRAMES_DEF = 60;

endpackage

// File: rtl/game_ctrl_frame_timer.sv
// frame_timer: loadable down-counter used for the respawn delay.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (count -> 0)
//   i_load       load i_load_val (wins over i_en)
//   i_load_val   value to load
//   i_en         count enable (one step per frame_tick)
//   o_zero       counter is at zero
module frame_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   // Count stops at zero, so the enable can be tied straight to frame_tick
   // without the counter wrapping outside the dying phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: central game sequencer. Owns the game FSM, life counter,
// saturating score counter and the frame-based respawn delay.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   frame_tick          one pulse per frame
//   start               start-key pulse
//   dead_hit, goal_hit  collision pulses from the detectors
//   game_stop           ball frozen (every state except PLAY)
//   game_over, game_win overlay selects
//   ball_reset          one-cycle pulse: reload ball to spawn
//   life, score         counters for the text overlay
//   state               current state encoding (debug)
module game_ctrl
   import game_pkg::*;
#(
   parameter int LIFE_INIT      = LIFE_INIT_DEF,
   parameter int LIFE_W         = 2,
   parameter int SCORE_W        = 4,
   parameter int WIN_SCORE      = WIN_SCORE_DEF,
   parameter int RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
   parameter int TMR_W          = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               start,
   input  logic               dead_hit,
   input  logic               goal_hit,
   output logic               game_stop,
   output logic               game_over,
   output logic               game_win,
   output logic               ball_reset,
   output logic [LIFE_W-1:0]  life,
   output logic [SCORE_W-1:0] score,
   output logic [2:0]         state
);

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
   localparam logic [LIFE_W-1:0]  LIFE_LOAD = LIFE_W'(LIFE_INIT);
   localparam logic [TMR_W-1:0]   TMR_LOAD  = TMR_W'(RESPAWN_FRAMES - 1);

   game_state_t        r_state;
   logic [LIFE_W-1:0]  r_life;
   logic [SCORE_W-1:0] r_score;
   logic               r_ball_reset;

   game_state_t        w_state_nxt;
   logic [LIFE_W-1:0]  w_life_nxt;
   logic [SCORE_W-1:0] w_score_nxt;
   logic [SCORE_W-1:0] w_score_inc;
   logic               w_ball_reset_nxt;
   logic               w_tmr_load;
   logic               w_tmr_zero;

   frame_timer #(.W(TMR_W)) u_frame_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_tmr_load),
      .i_load_val (TMR_LOAD),
      .i_en       (frame_tick),
      .o_zero     (w_tmr_zero)
   );

   assign w_score_inc = (r_score == SCORE_MAX) ? r_score : r_score + SCORE_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_life       <= LIFE_LOAD;
         r_score      <= '0;
         r_ball_reset <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_life       <= w_life_nxt;
         r_score      <= w_score_nxt;
         r_ball_reset <= w_ball_reset_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_life_nxt       = r_life;
      w_score_nxt      = r_score;
      w_ball_reset_nxt = 1'b0;
      w_tmr_load       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt      = S_PLAY;
               w_life_nxt       = LIFE_LOAD;
               w_score_nxt      = '0;
               w_ball_reset_nxt = 1'b1;
            end
         end
         S_PLAY: begin
            // Goal outranks a simultaneous death.
            if (goal_hit) begin
               w_score_nxt = w_score_inc;
               if (w_score_inc >= WIN_VAL) begin
                  w_state_nxt = S_WIN;
               end else begin
                  w_ball_reset_nxt = 1'b1;
               end
            end else if (dead_hit) begin
               if (r_life == '0) begin
                  w_state_nxt = S_OVER;
               end else begin
                  w_state_nxt = S_DYING;
                  w_life_nxt  = r_life - LIFE_W'(1);
                  w_tmr_load  = 1'b1;
               end
            end
         end
         S_DYING: begin
            // Timer loaded with N-1 expires on the N-th frame_tick.
            if (frame_tick && w_tmr_zero) begin
               w_state_nxt      = S_NEWBALL;
               w_ball_reset_nxt = 1'b1;
            end
         end
         S_NEWBALL: begin
            if (start) begin
               w_state_nxt = S_PLAY;
            end
         end
         S_OVER, S_WIN: begin
            // Counters hold so the overlay keeps showing the final values.
            if (start) begin
               w_state_nxt      = S_IDLE;
               w_ball_reset_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign game_stop  = (r_state != S_PLAY);
   assign game_over  = (r_state == S_OVER);
   assign game_win   = (r_state == S_WIN);
   assign ball_reset = r_ball_reset;
   assign life       = r_life;
   assign score      = r_score;
   assign state      = r_state;

endmodule
